// File: rtl/phase_counter.sv
// -----------------------------------------------------------------------------
// phase_counter
//
// Timing counter and result capture for the dual-slope voltmeter. The
// measurement FSM drives the counter through clear/enable/limit and reads back
// done/busy. On the end-of-conversion strobe the current count is latched into
// a single-entry result buffer that downstream logic drains with valid/ready.
//
// Optional feature macro: PHASE_COUNTER_SIGN_EN
//   defined   - the reference polarity seen on the last clear is carried into
//               the result as result_sign_o
//   undefined - no sign storage, result_sign_o is tied low
//
// Ports
//   clk_i            in   clock
//   rst_n_i          in   asynchronous active-low reset
//   counter_clear_i  in   synchronous clear request from FSM
//   counter_en_i     in   count enable from FSM
//   counter_limit_i  in   terminal count for the current phase
//   capture_i        in   end-of-conversion strobe
//   ref_sign_i       in   reference polarity from FSM
//   counter_done_o   out  count has reached limit (level)
//   counter_busy_o   out  counting in progress
//   result_o         out  captured count
//   result_sign_o    out  captured polarity
//   result_ovf_o     out  captured count had saturated at limit
//   result_valid_o   out  result buffer full
//   result_ready_i   in   downstream accepts result
//   overrun_o        out  sticky: an unread result was overwritten
// -----------------------------------------------------------------------------
module phase_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             counter_clear_i,
    input  logic             counter_en_i,
    input  logic [WIDTH-1:0] counter_limit_i,
    input  logic             capture_i,
    input  logic             ref_sign_i,
    output logic             counter_done_o,
    output logic             counter_busy_o,
    output logic [WIDTH-1:0] result_o,
    output logic             result_sign_o,
    output logic             result_ovf_o,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic             overrun_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_ONES = '1;

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_ovf;
    logic             r_valid;
    logic             r_overrun;

    logic [WIDTH-1:0] w_cnt_inc;
    logic             w_handshake;
    logic             w_reach;

    assign w_cnt_inc   = r_cnt + CNT_ONE;
    assign w_handshake = r_valid & result_ready_i;

    // The terminal compare is equality-only, so a limit lowered below the
    // current count during RUN is never matched; all-ones acts as an implicit
    // limit so the counter parks there instead of wrapping to zero.
    assign w_reach = (w_cnt_inc == counter_limit_i) || (w_cnt_inc == CNT_ONES);

    // Phase counter and its state. Capture outranks clear, and clear outranks
    // counting, so the FSM's end-of-conversion strobe always returns the
    // counter to IDLE with a zero count whatever else is requested that cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (capture_i || counter_clear_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (counter_en_i) begin
                        // A zero limit is already satisfied: go straight to
                        // HIT without counting.
                        if (counter_limit_i == '0) begin
                            r_state <= HIT;
                        end else begin
                            r_cnt   <= CNT_ONE;
                            r_state <= (counter_limit_i == CNT_ONE) ? HIT : RUN;
                        end
                    end
                end
                RUN: begin
                    if (counter_en_i) begin
                        r_cnt <= w_cnt_inc;
                        if (w_reach) begin
                            r_state <= HIT;
                        end
                    end
                end
                HIT: begin
                    // Count and state are frozen; limit changes are ignored
                    // until clear, capture or reset.
                    r_state <= HIT;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Single-entry result buffer. A capture loads the count and marks the
    // buffer full; a capture landing on a full buffer that is not being read
    // that cycle loses the old value and raises the sticky overrun flag. A
    // capture coincident with a handshake hands the old value over and keeps
    // the buffer full with the new one, which is a normal read.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_result  <= '0;
            r_ovf     <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (capture_i) begin
            r_result <= r_cnt;
            r_ovf    <= (r_state == HIT);
            r_valid  <= 1'b1;
            if (r_valid && !result_ready_i) begin
                r_overrun <= 1'b1;
            end else if (w_handshake) begin
                r_overrun <= 1'b0;
            end
        end else if (w_handshake) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

`ifdef PHASE_COUNTER_SIGN_EN
    logic r_sign_hold;
    logic r_result_sign;

    // The polarity is sampled on every clear that is not overridden by a
    // capture; the last such clear before capture is the integrate to
    // de-integrate transition, which is the sign the readout needs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sign_hold   <= 1'b0;
            r_result_sign <= 1'b0;
        end else if (capture_i) begin
            r_result_sign <= r_sign_hold;
        end else if (counter_clear_i) begin
            r_sign_hold <= ref_sign_i;
        end
    end

    assign result_sign_o = r_result_sign;
`else
    logic w_unused_ref_sign;

    assign w_unused_ref_sign = ref_sign_i;
    assign result_sign_o     = 1'b0;
`endif

    assign counter_busy_o = (r_state == RUN);
    assign counter_done_o = (r_state == HIT);
    assign result_o       = r_result;
    assign result_ovf_o   = r_ovf;
    assign result_valid_o = r_valid;
    assign overrun_o      = r_overrun;

endmodule
